// File: rtl/vga_fb_reader.sv
// Reads the 320x240 RGB565 frame buffer and scans it out as 640x480@60 VGA with 2x2 replication.
// The pipeline has three stages (counter, address, output), so sync and frame_start move with the pixels.
module vga_fb_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = 320,
   parameter int FB_H     = 240
) (
   input  logic        clk,
   input  logic        rst,
   output logic [16:0] rd_addr,
   input  logic [15:0] rd_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  V_ODD_LIM  = 10'(2 * FB_H - 1);
   localparam logic [16:0] LINE_STEP  = 17'(FB_W);

   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic [16:0] line_base;

   logic active0, hs0, vs0, fs0;
   logic act1, hs1, vs1, fs1;
   logic act2, hs2, vs2, fs2;

   logic unused_rd_bits;
   assign unused_rd_bits = ^{rd_data[11], rd_data[6:5], rd_data[0]};

   always_comb begin
      active0 = (hcnt < H_ACT) && (vcnt < V_ACT);
      hs0     = !((hcnt >= HS_BEG) && (hcnt < HS_END));
      vs0     = !((vcnt >= VS_BEG) && (vcnt < VS_END));
      fs0     = (hcnt == 10'd0) && (vcnt == 10'd0);
   end

   // line_base advances after every second active line, so each buffer row is shown twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt      <= '0;
         vcnt      <= '0;
         line_base <= '0;
      end else if (hcnt == H_MAX) begin
         hcnt <= '0;
         if (vcnt == V_MAX) begin
            vcnt      <= '0;
            line_base <= '0;
         end else begin
            vcnt <= vcnt + 10'd1;
            if (vcnt[0] && (vcnt < V_ODD_LIM))
               line_base <= line_base + LINE_STEP;
         end
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr <= '0;
         act1    <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
         fs1     <= 1'b0;
         act2    <= 1'b0;
         hs2     <= 1'b1;
         vs2     <= 1'b1;
         fs2     <= 1'b0;
      end else begin
         rd_addr <= active0 ? (line_base + {8'd0, hcnt[9:1]}) : '0;
         act1    <= active0;
         hs1     <= hs0;
         vs1     <= vs0;
         fs1     <= fs0;
         act2    <= act1;
         hs2     <= hs1;
         vs2     <= vs1;
         fs2     <= fs1;
      end
   end

   // The top bits of each RGB565 field drive the 4-bit DACs.
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= act2 ? rd_data[15:12] : 4'd0;
         vga_g       <= act2 ? rd_data[10:7]  : 4'd0;
         vga_b       <= act2 ? rd_data[4:1]   : 4'd0;
         hsync       <= hs2;
         vsync       <= vs2;
         frame_start <= fs2;
      end
   end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader. A full-size instance checks the real timing and addresses.
// A shrunken instance runs whole frames quickly so that wrap and boundary behaviour is exercised.
module tb_vga_fb_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] rd_addr, rd_addr_s;
   logic [15:0] rd_data, rd_data_s;
   logic [3:0]  vga_r, vga_g, vga_b, r_s, g_s, b_s;
   logic        hsync, vsync, frame_start, hsync_s, vsync_s, fs_s;
   logic        use_const;
   logic [15:0] const_word;
   int          tests, fails, n;

   always #20 clk = ~clk;

   // Synchronous BRAM models: word(a) = a[15:0], or a constant word for the colour checks.
   always @(posedge clk) begin
      rd_data   <= use_const ? const_word : rd_addr[15:0];
      rd_data_s <= rd_addr_s[15:0];
   end

   vga_fb_reader dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
   );

   vga_fb_reader #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .FB_W(8), .FB_H(4)
   ) dut_s (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
      .hsync(hsync_s), .vsync(vsync_s), .frame_start(fs_s)
   );

   function automatic logic [16:0] big_addr(input int p);
      int h = p % 800;
      int v = (p / 800) % 525;
      if (h < 640 && v < 480) return 17'((v / 2) * 320 + h / 2);
      return 17'd0;
   endfunction

   function automatic bit big_act(input int p);
      return ((p % 800) < 640) && (((p / 800) % 525) < 480);
   endfunction

   function automatic logic [16:0] small_addr(input int p);
      int h = p % 24;
      int v = (p / 24) % 13;
      if (h < 16 && v < 8) return 17'((v / 2) * 8 + h / 2);
      return 17'd0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (4) tick;
      tests++;
      if (rd_addr !== 17'd0) begin
         fails++; $display("[TB] FAIL reset rd_addr: got %0d want 0", rd_addr);
      end
      tests++;
      if ({vga_r, vga_g, vga_b} !== 12'h000) begin
         fails++; $display("[TB] FAIL reset rgb: got %h want 000", {vga_r, vga_g, vga_b});
      end
      tests++;
      if ({hsync, vsync, frame_start} !== 3'b110) begin
         fails++; $display("[TB] FAIL reset sync: got %b want 110", {hsync, vsync, frame_start});
      end
      tests++;
      if ({rd_addr_s, r_s, g_s, b_s, hsync_s, vsync_s, fs_s} !== {17'd0, 12'h000, 3'b110}) begin
         fails++; $display("[TB] FAIL reset small: got %h", {rd_addr_s, r_s, g_s, b_s, hsync_s, vsync_s, fs_s});
      end
   endtask

   // Full-size timing: per-cycle addresses, RGB, syncs and frame_start, plus hand-picked addresses.
   task automatic test_timing_big(input int last);
      logic [16:0] ea;
      logic [15:0] w;
      logic [11:0] ergb;
      bit          ehs, evs, efs;
      int          q, h, pulses, low_total, first_fall, second_fall;
      logic        prev_hs;
      pulses = 0; low_total = 0; first_fall = -1; second_fall = -1; prev_hs = 1'b1;
      while (n < last) begin
         tick;
         ea = big_addr(n - 1);
         tests++;
         if (rd_addr !== ea) begin
            fails++; $display("[TB] FAIL big rd_addr n=%0d: got %0d want %0d", n, rd_addr, ea);
         end
         ergb = 12'h000; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
         if (n >= 3) begin
            q = n - 3;
            h = q % 800;
            ea = big_addr(q);
            w = ea[15:0];
            if (big_act(q)) ergb = {w[15:12], w[10:7], w[4:1]};
            ehs = !(h >= 656 && h < 752);
            efs = (q % 420000) == 0;
         end
         tests++;
         if ({vga_r, vga_g, vga_b} !== ergb) begin
            fails++; $display("[TB] FAIL big rgb n=%0d: got %h want %h", n, {vga_r, vga_g, vga_b}, ergb);
         end
         tests++;
         if ({hsync, vsync, frame_start} !== {ehs, evs, efs}) begin
            fails++; $display("[TB] FAIL big sync n=%0d: got %b want %b", n, {hsync, vsync, frame_start}, {ehs, evs, efs});
         end
         case (n)
            1, 2, 801: ea = 17'd0;
            3:         ea = 17'd1;
            640:       ea = 17'd319;
            1501:      ea = 17'd0;
            1601:      ea = 17'd320;
            default:   ea = 17'h1FFFF;
         endcase
         if (ea != 17'h1FFFF) begin
            tests++;
            if (rd_addr !== ea) begin
               fails++; $display("[TB] FAIL addr point n=%0d: got %0d want %0d", n, rd_addr, ea);
            end
         end
         if (!hsync) low_total++;
         if (prev_hs && !hsync) begin
            pulses++;
            if (first_fall < 0) first_fall = n;
            else if (second_fall < 0) second_fall = n;
         end
         prev_hs = hsync;
      end
      tests++;
      if (pulses !== 3 || low_total !== 288) begin
         fails++; $display("[TB] FAIL hsync pulses: got %0d/%0d want 3/288", pulses, low_total);
      end
      tests++;
      if (second_fall - first_fall !== 800) begin
         fails++; $display("[TB] FAIL line period: got %0d want 800", second_fall - first_fall);
      end
   endtask

   // Shrunken instance: 24x13 totals, 16x8 active, 8x4 buffer, frame period 312.
   task automatic test_small_frames(input int cycles);
      logic [16:0] ea;
      logic [15:0] w;
      logic [3:0]  eb;
      bit          ehs, evs, efs;
      int          q, h, v, pulses;
      pulses = 0;
      repeat (cycles) begin
         tick;
         ea = small_addr(n - 1);
         tests++;
         if (rd_addr_s !== ea) begin
            fails++; $display("[TB] FAIL small rd_addr n=%0d: got %0d want %0d", n, rd_addr_s, ea);
         end
         if (((n - 1) % 312) == 183) begin
            tests++;
            if (rd_addr_s !== 17'd31) begin
               fails++; $display("[TB] FAIL small last addr: got %0d want 31", rd_addr_s);
            end
         end
         eb = 4'd0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
         if (n >= 3) begin
            q = n - 3;
            h = q % 24;
            v = (q / 24) % 13;
            ea = small_addr(q);
            w = ea[15:0];
            if (h < 16 && v < 8) eb = w[4:1];
            ehs = !(h >= 18 && h < 21);
            evs = !(v >= 9 && v < 11);
            efs = (q % 312) == 0;
         end
         tests++;
         if ({b_s, hsync_s, vsync_s, fs_s} !== {eb, ehs, evs, efs}) begin
            fails++; $display("[TB] FAIL small out n=%0d: got %b want %b", n, {b_s, hsync_s, vsync_s, fs_s}, {eb, ehs, evs, efs});
         end
         if (fs_s) pulses++;
      end
      tests++;
      if (pulses !== 2) begin
         fails++; $display("[TB] FAIL small frame_start count: got %0d want 2", pulses);
      end
   endtask

   task automatic test_pixel_3_5;
      while (n < 4004) tick;
      tests++;
      if (rd_addr !== 17'd641) begin
         fails++; $display("[TB] FAIL pixel(3,5) addr: got %0d want 641", rd_addr);
      end
      repeat (2) tick;
      tests++;
      if ({vga_r, vga_g, vga_b} !== 12'h050) begin
         fails++; $display("[TB] FAIL pixel(3,5) rgb: got %h want 050", {vga_r, vga_g, vga_b});
      end
   endtask

   task automatic test_colour(input logic [15:0] word, input logic [11:0] rgb);
      logic [11:0] e;
      use_const = 1'b1;
      const_word = word;
      repeat (2) tick;
      repeat (800) begin
         tick;
         e = big_act(n - 3) ? rgb : 12'h000;
         tests++;
         if ({vga_r, vga_g, vga_b} !== e) begin
            fails++; $display("[TB] FAIL colour %h n=%0d: got %h want %h", word, n, {vga_r, vga_g, vga_b}, e);
         end
      end
      use_const = 1'b0;
   endtask

   task automatic test_mid_reset;
      while ((n % 312) != 132) tick;
      rst = 1'b1;
      repeat (3) begin
         tick;
         tests++;
         if ({r_s, g_s, b_s, hsync_s, vsync_s, vga_r, vga_g, vga_b, hsync, vsync} !== {12'h000, 2'b11, 12'h000, 2'b11}) begin
            fails++; $display("[TB] FAIL mid reset hold: got small %h%b big %h%b", {r_s, g_s, b_s}, {hsync_s, vsync_s}, {vga_r, vga_g, vga_b}, {hsync, vsync});
         end
      end
      rst = 1'b0;
      n = 0;
      repeat (2) begin
         tick;
         tests++;
         if ({r_s, g_s, b_s, hsync_s, vsync_s, fs_s, vga_r, vga_g, vga_b, hsync, vsync, frame_start} !== {12'h000, 3'b110, 12'h000, 3'b110}) begin
            fails++; $display("[TB] FAIL mid reset release n=%0d: got small %b big %b", n, {hsync_s, vsync_s, fs_s}, {hsync, vsync, frame_start});
         end
      end
      test_small_frames(313);
   endtask

   initial begin
      tests = 0; fails = 0; n = 0;
      use_const = 1'b0;
      const_word = 16'h0000;
      test_reset;
      rst = 1'b0;
      n = 0;
      test_timing_big(3 * 800 + 3);
      test_small_frames(624);
      test_pixel_3_5;
      test_colour(16'hFFFF, 12'hFFF);
      test_colour(16'hF800, 12'hF00);
      test_colour(16'h07E0, 12'h0F0);
      test_mid_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
